// File: rtl/pri_encoder_rr_pkg.sv
// Shared definitions for the registered priority encoder / round-robin arbiter.
package pri_encoder_rr_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Index width for n lines; never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/pri_encoder_rr_enc.sv
// Combinational N-input priority encoder; HIGH_FIRST picks the highest set bit, else the lowest.
module pri_encoder_n
   import pri_encoder_rr_pkg::*;
#(
   parameter int  N          = 8,
   parameter bit  HIGH_FIRST = 1'b1,
   localparam int W          = clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      idx = '0;
      any = |vec;
      if (HIGH_FIRST) begin
         for (int i = 0; i < N; i++)
            if (vec[i]) idx = W'(i);
      end else begin
         for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/pri_encoder_rr.sv
// Registered N-way arbiter: holds one grant until ack, then re-arbitrates in fixed or round-robin order.
module pri_encoder_rr
   import pri_encoder_rr_pkg::*;
#(
   parameter int  N    = 8,
   parameter int  MODE = MODE_FIXED,
   localparam int W    = clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic [W-1:0] y,
   output logic [N-1:0] g,
   output logic         v
);

   state_t         state_p1, state_d;
   logic [W-1:0]   y_p1, y_d;
   logic [N-1:0]   g_p1, g_d;
   logic           vld_p1, vld_d;
   logic [W-1:0]   ptr_p1, ptr_d;
   logic [W-1:0]   ptr_wrap;
   logic [W-1:0]   search_ptr;
   logic [W-1:0]   sel_idx;
   logic           req_any;
   logic           done;

   assign done       = (state_p1 == GRANT) && ack;
   assign ptr_wrap   = (y_p1 == W'(N - 1)) ? '0 : y_p1 + W'(1);
   // On a completing grant the search already starts just past the acked source.
   assign search_ptr = done ? ((MODE == MODE_RR) ? ptr_wrap : '0) : ptr_p1;

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic [N-1:0] mask;
         logic [N-1:0] masked;
         logic [W-1:0] m_idx, u_idx;
         logic         m_any, u_any;

         always_comb begin
            mask = '0;
            for (int i = 0; i < N; i++)
               mask[i] = (i >= int'(search_ptr));
         end
         assign masked = req & mask;

         pri_encoder_n #(.N(N), .HIGH_FIRST(1'b0)) u_masked (
            .vec (masked),
            .idx (m_idx),
            .any (m_any)
         );
         pri_encoder_n #(.N(N), .HIGH_FIRST(1'b0)) u_full (
            .vec (req),
            .idx (u_idx),
            .any (u_any)
         );

         assign sel_idx = m_any ? m_idx : u_idx;
         assign req_any = u_any;
      end else begin : g_fixed
         logic unused_ptr;
         assign unused_ptr = ^search_ptr;

         pri_encoder_n #(.N(N), .HIGH_FIRST(1'b1)) u_full (
            .vec (req),
            .idx (sel_idx),
            .any (req_any)
         );
      end
   endgenerate

   always_comb begin
      state_d = state_p1;
      y_d     = y_p1;
      g_d     = g_p1;
      vld_d   = vld_p1;
      ptr_d   = ptr_p1;
      unique case (state_p1)
         IDLE: begin
            if (req_any) begin
               state_d = GRANT;
               y_d     = sel_idx;
               g_d     = {{(N-1){1'b0}}, 1'b1} << sel_idx;
               vld_d   = 1'b1;
            end
         end
         GRANT: begin
            if (ack) begin
               ptr_d = search_ptr;
               if (req_any) begin
                  y_d = sel_idx;
                  g_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
               end else begin
                  state_d = IDLE;
                  g_d     = '0;
                  vld_d   = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/state register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1 <= IDLE;
         y_p1     <= '0;
         g_p1     <= '0;
         vld_p1   <= 1'b0;
         ptr_p1   <= '0;
      end else begin
         state_p1 <= state_d;
         y_p1     <= y_d;
         g_p1     <= g_d;
         vld_p1   <= vld_d;
         ptr_p1   <= ptr_d;
      end
   end

   assign y = y_p1;
   assign g = g_p1;
   assign v = vld_p1;

endmodule

// File: doc/pri_encoder_rr.md
# pri_encoder_rr

Parametrised, registered N-input priority encoder/arbiter with a selectable fixed-priority or round-robin mode. It holds one granted index at a time until the consumer acknowledges it, then re-arbitrates.

It generalises the combinational 4-to-2 priority encoder into a sequential block. It sits between N request sources and a single shared consumer, for example a bus or output port.

## Interface
Parameters:
- N, 8, number of request lines; N ≥ 2.
- W, clog2(N), width of the index output; derived, not overridden.
- MODE, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i set = source i requests.
- ack  input  1  consumer has accepted the current grant; meaningful only while v=1.
- y  output  W  registered index of the granted source.
- g  output  N  registered one-hot grant, equal to 1<<y while v=1; all zero otherwise.
- v  output  1  registered valid: a grant is held.

## Operation
- FSM states: IDLE (v=0) and GRANT (v=1).
- Arbitration function sel(req, ptr):
  - MODE 0: highest set index of req; ptr is ignored.
  - MODE 1: first set index searching ptr, ptr+1, …, N-1, 0, …, ptr-1, with modulo-N wrap.
- IDLE:
  - req≠0: load y=sel(req,ptr), g=1<<y, v=1, go to GRANT.
  - req=0: stay in IDLE.
  - ack is ignored.
- GRANT without ack: y, g and v hold. Changes on req are ignored; the grant is sticky even if the granted request drops.
- GRANT with ack:
  - Compute ptr' = (y+1) mod N. In MODE 1 ptr is updated to ptr'; in MODE 0 ptr stays 0.
  - If req≠0, load y=sel(req,ptr') and stay in GRANT. This gives back-to-back grants with no bubble.
  - If req=0, go to IDLE: v=0, g=0, y holds its last value.
- The req bit of the source being acked is still considered in re-arbitration. In MODE 1 it is searched last.
- Reset values: y=0, g=0, v=0, ptr=0, state IDLE.
- Reset dominates req and ack in the same cycle.

## Timing
- Latency: req sampled at edge k gives y/g/v valid after edge k. That is one cycle; there is no combinational path from req to any output.
- Handshake:
  - A grant completes on the edge where v=1 and ack=1.
  - The new grant, or v=0, is visible immediately after that edge.
  - Sustained throughput is one grant per cycle.
- Reset mid-grant: outputs clear after the reset edge. The acked or pending grant is lost and ptr returns to 0.
- Wrap-around: ptr' after y=N-1 is 0.
- Simultaneous req rise and ack: the new request takes part in that cycle's re-arbitration.

## Structure
Shared package:
- Constants MODE_FIXED=0 and MODE_RR=1.
- clog2 function.
- FSM state encoding: IDLE, GRANT.

Sub-module:
- One combinational sub-module, pri_encoder_n (parameter N): input vector, outputs index and any.
- Round-robin search uses two instances:
  - Masked search: req & ~((1<<ptr)-1).
  - Unmasked search on req.
  - Use the masked result when it is non-empty.
- Fixed mode uses the unmasked instance only.
- Top level holds the FSM, the ptr register and the output registers.

## Test plan
1. MODE 0, N=8, req=8'b0010_1100 for one cycle then 0, ack low:
   - Next cycle y=5, g=8'b0010_0000, v=1, held indefinitely.
   - Ack one cycle later gives v=0, g=0.
2. MODE 1, N=8, after reset, req=8'hFF constant, ack=1 every cycle:
   - y sequence 0,1,2,…,7,0,1 with v continuously 1.
3. MODE 1 wrap, current y=6, req=8'b0100_0001, ack:
   - Next y=0 (search 7,0).
   - Ack again gives y=6 (search 1..6).
4. MODE 0, grant y=3 held, req drops to 0 before ack:
   - y=3 and v=1 hold until ack.
   - After ack, v=0 and the FSM is IDLE.
5. Reset mid-grant with ack=1 and req=8'hFF:
   - After the edge y=0, g=0, v=0.
   - After rst is released, the first MODE 1 grant is y=0.
6. IDLE with req=0 and ack pulsed:
   - No output change.
   - v stays 0 and ptr is unchanged, checked via the next grant index.
